instr_encoder: RTL



---
 rtl/instr_encoder.sv | 91 +++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs imm16/Rd/Rt/Rs into 32-bit words, buffers them in a small FIFO and
// streams them out with sequential addresses. Optional word_count: INSTR_ENC_COUNT_EN.
module instr_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned ADDR_BASE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       imm16,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr
`ifdef INSTR_ENC_COUNT_EN
    ,
    output logic [15:0]       word_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Handshake outputs depend on registered count only.
    always_comb begin
        in_ready  = (count != CW'(DEPTH));
        out_valid = (count != '0);
        out_instr = out_valid ? mem[rd_ptr] : '0;
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {imm16, 1'b0, Rd, Rt, Rs};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= ADDR_W'(ADDR_BASE);
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out_addr <= ADDR_W'(ADDR_BASE);
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_addr <= out_addr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef INSTR_ENC_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (flush) begin
            word_count <= '0;
        end else if (pop && (word_count != '1)) begin
            word_count <= word_count + 16'd1;
        end
    end
`endif

endmodule
